multicycle_control_unit: RTL

- Moore FSM that sequences the multicycle MIPS-subset datapath: PC, memory, IR, register bank, A/B, ALU, ALUOut, MDR and EPC.
- Each cycle it drives every write enable, the mux selects and the ALU op code from the current state, plus IR opcode/funct and ALU flags.
- Supported instructions: R-type add/sub/and/jr, addi, lw, sw, beq, bne, j.
- Exceptions: overflow and invalid opcode.

---
 rtl/cu_pkg.sv | 79 +++++++
 rtl/multicycle_control_unit_if.sv | 42 ++++
 rtl/multicycle_control_unit_wait_counter.sv | 30 +++
 rtl/multicycle_control_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared encodings for the multicycle control unit: FSM states,
// instruction fields, ALU codes and datapath mux selects.
package cu_pkg;

   typedef enum logic [4:0] {
      S_RESET   = 5'd0,
      S_FETCH   = 5'd1,
      S_DECODE  = 5'd2,
      S_EXEC_R  = 5'd3,
      S_WB_R    = 5'd4,
      S_EXEC_I  = 5'd5,
      S_WB_I    = 5'd6,
      S_ADDR    = 5'd7,
      S_MEM_RD  = 5'd8,
      S_WB_L    = 5'd9,
      S_MEM_WR  = 5'd10,
      S_BRANCH  = 5'd11,
      S_JUMP    = 5'd12,
      S_JR      = 5'd13,
      S_EXC_OVF = 5'd14,
      S_EXC_OPC = 5'd15,
      S_EXC_JMP = 5'd16
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_JR  = 6'h08;

   localparam logic [2:0] ULA_PASSA = 3'b000;
   localparam logic [2:0] ULA_ADD   = 3'b001;
   localparam logic [2:0] ULA_SUB   = 3'b010;
   localparam logic [2:0] ULA_AND   = 3'b011;

   localparam logic [1:0] MEM_PC     = 2'd0;
   localparam logic [1:0] MEM_ALUOUT = 2'd1;

   localparam logic [1:0] WR_RT = 2'd0;
   localparam logic [1:0] WR_RD = 2'd1;
   localparam logic [1:0] WR_SP = 2'd2;

   localparam logic [1:0] WD_ALUOUT = 2'd0;
   localparam logic [1:0] WD_MDR    = 2'd1;
   localparam logic [1:0] WD_SP     = 2'd2;

   localparam logic A_PC  = 1'b0;
   localparam logic A_REG = 1'b1;

   localparam logic [1:0] B_REG     = 2'd0;
   localparam logic [1:0] B_FOUR    = 2'd1;
   localparam logic [1:0] B_SEXT    = 2'd2;
   localparam logic [1:0] B_SEXT_SH = 2'd3;

   localparam logic [1:0] PC_ULA    = 2'd0;
   localparam logic [1:0] PC_ALUOUT = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;
   localparam logic [1:0] PC_EXC    = 2'd3;

   function automatic logic is_r_alu(input logic [5:0] fn);
      return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND);
   endfunction

   function automatic logic [2:0] r_ula(input logic [5:0] fn);
      logic [2:0] c;
      c = ULA_ADD;
      if (fn == FN_SUB) c = ULA_SUB;
      if (fn == FN_AND) c = ULA_AND;
      return c;
   endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the control unit (master) and the
// multicycle datapath (slave).
interface multicycle_control_unit_if;

   logic [5:0] OPCODE;
   logic [5:0] FUNCT;
   logic       Of;
   logic       Zr;
   logic       PC_w;
   logic       MEM_w;
   logic       IR_w;
   logic       RB_w;
   logic       AB_w;
   logic       ULA_w;
   logic       MDR_w;
   logic       EPC_w;
   logic [2:0] ULA_c;
   logic [1:0] M_selector_Memory;
   logic [1:0] M_selector_writereg;
   logic [1:0] M_selector_WDATA;
   logic       M_selector_A;
   logic [1:0] M_selector_B;
   logic [1:0] M_selector_PCsrc;
   logic       exc_cause;

   modport master (
      input  OPCODE, FUNCT, Of, Zr,
      output PC_w, MEM_w, IR_w, RB_w, AB_w, ULA_w, MDR_w, EPC_w,
      output ULA_c, M_selector_Memory, M_selector_writereg,
      output M_selector_WDATA, M_selector_A, M_selector_B,
      output M_selector_PCsrc, exc_cause
   );

   modport slave (
      output OPCODE, FUNCT, Of, Zr,
      input  PC_w, MEM_w, IR_w, RB_w, AB_w, ULA_w, MDR_w, EPC_w,
      input  ULA_c, M_selector_Memory, M_selector_writereg,
      input  M_selector_WDATA, M_selector_A, M_selector_B,
      input  M_selector_PCsrc, exc_cause
   );

endinterface

// File: rtl/multicycle_control_unit_wait_counter.sv
// Memory wait counter: done once the current memory state has
// been held for MEM_WAIT extra cycles.
module cu_wait_counter #(
   parameter int MEM_WAIT = 1
) (
   input  logic clk,
   input  logic clr,
   input  logic en,
   output logic done
);

   logic [1:0] cnt_q;
   logic [1:0] cnt_d;

   assign done = (cnt_q == 2'(MEM_WAIT));

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = 2'd0;
      end else if (en && !done) begin
         cnt_d = cnt_q + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM sequencing the multicycle MIPS-subset datapath.
// Outputs decode from the state; BRANCH also looks at Zr.
module multicycle_control_unit
   import cu_pkg::*;
#(
   parameter int MEM_WAIT = 1,
   parameter int SP_INIT  = 227
) (
   input logic                        clk,
   input logic                        reset,
   multicycle_control_unit_if.master  cu
);

   if (MEM_WAIT < 0 || MEM_WAIT > 3 || SP_INIT < 0) begin : g_bad_param
      $error("multicycle_control_unit: parameter out of range");
   end

   state_e state_q;
   state_e state_d;
   logic   exc_q;
   logic   exc_d;
   logic   wait_done;
   logic   wait_st;
   logic   wait_clr;

   assign wait_st  = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                     (state_q == S_MEM_WR);
   assign wait_clr = reset || (state_d != state_q);

   cu_wait_counter #(
      .MEM_WAIT (MEM_WAIT)
   ) u_wait (
      .clk  (clk),
      .clr  (wait_clr),
      .en   (wait_st),
      .done (wait_done)
   );

   always_comb begin
      state_d = S_RESET;
      exc_d   = exc_q;
      case (state_q)
         S_RESET:  state_d = S_FETCH;
         S_FETCH:  state_d = wait_done ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (cu.OPCODE)
               OP_RTYPE: begin
                  if (is_r_alu(cu.FUNCT))     state_d = S_EXEC_R;
                  else if (cu.FUNCT == FN_JR) state_d = S_JR;
                  else                        state_d = S_EXC_OPC;
               end
               OP_ADDI:       state_d = S_EXEC_I;
               OP_LW, OP_SW:  state_d = S_ADDR;
               OP_BEQ, OP_BNE: state_d = S_BRANCH;
               OP_J:          state_d = S_JUMP;
               default:       state_d = S_EXC_OPC;
            endcase
         end
         // and cannot overflow, so only add/sub trap
         S_EXEC_R: state_d = (cu.Of && cu.FUNCT != FN_AND) ? S_EXC_OVF : S_WB_R;
         S_EXEC_I: state_d = cu.Of ? S_EXC_OVF : S_WB_I;
         S_ADDR:   state_d = (cu.OPCODE == OP_SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD: state_d = wait_done ? S_WB_L : S_MEM_RD;
         S_MEM_WR: state_d = wait_done ? S_FETCH : S_MEM_WR;
         S_WB_R, S_WB_I, S_WB_L,
         S_BRANCH, S_JUMP, S_JR: state_d = S_FETCH;
         S_EXC_OVF: begin
            state_d = S_EXC_JMP;
            exc_d   = 1'b0;
         end
         S_EXC_OPC: begin
            state_d = S_EXC_JMP;
            exc_d   = 1'b1;
         end
         S_EXC_JMP: state_d = S_FETCH;
         default:   state_d = S_RESET;
      endcase
      if (reset) begin
         state_d = S_RESET;
         exc_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      state_q <= state_d;
      exc_q   <= exc_d;
   end

   always_comb begin
      cu.PC_w                = 1'b0;
      cu.MEM_w               = 1'b0;
      cu.IR_w                = 1'b0;
      cu.RB_w                = 1'b0;
      cu.AB_w                = 1'b0;
      cu.ULA_w               = 1'b0;
      cu.MDR_w               = 1'b0;
      cu.EPC_w               = 1'b0;
      cu.ULA_c               = ULA_PASSA;
      cu.M_selector_Memory   = MEM_PC;
      cu.M_selector_writereg = WR_RT;
      cu.M_selector_WDATA    = WD_ALUOUT;
      cu.M_selector_A        = A_PC;
      cu.M_selector_B        = B_REG;
      cu.M_selector_PCsrc    = PC_ULA;
      cu.exc_cause           = 1'b0;
      case (state_q)
         S_RESET: begin
            cu.RB_w                = 1'b1;
            cu.M_selector_writereg = WR_SP;
            cu.M_selector_WDATA    = WD_SP;
         end
         S_FETCH: begin
            if (wait_done) begin
               cu.IR_w         = 1'b1;
               cu.PC_w         = 1'b1;
               cu.M_selector_B = B_FOUR;
               cu.ULA_c        = ULA_ADD;
            end
         end
         S_DECODE: begin
            cu.AB_w         = 1'b1;
            cu.ULA_w        = 1'b1;
            cu.M_selector_B = B_SEXT_SH;
            cu.ULA_c        = ULA_ADD;
         end
         S_EXEC_R: begin
            cu.M_selector_A = A_REG;
            cu.ULA_c        = r_ula(cu.FUNCT);
            cu.ULA_w        = 1'b1;
         end
         S_WB_R: begin
            cu.RB_w                = 1'b1;
            cu.M_selector_writereg = WR_RD;
         end
         S_EXEC_I, S_ADDR: begin
            cu.M_selector_A = A_REG;
            cu.M_selector_B = B_SEXT;
            cu.ULA_c        = ULA_ADD;
            cu.ULA_w        = 1'b1;
         end
         S_WB_I: cu.RB_w = 1'b1;
         S_MEM_RD: begin
            cu.M_selector_Memory = MEM_ALUOUT;
            cu.MDR_w             = wait_done;
         end
         S_WB_L: begin
            cu.RB_w             = 1'b1;
            cu.M_selector_WDATA = WD_MDR;
         end
         S_MEM_WR: begin
            cu.M_selector_Memory = MEM_ALUOUT;
            cu.MEM_w             = 1'b1;
         end
         S_BRANCH: begin
            cu.M_selector_A     = A_REG;
            cu.ULA_c            = ULA_SUB;
            cu.M_selector_PCsrc = PC_ALUOUT;
            cu.PC_w = (cu.OPCODE == OP_BNE) ? ~cu.Zr : cu.Zr;
         end
         S_JUMP: begin
            cu.M_selector_PCsrc = PC_JUMP;
            cu.PC_w             = 1'b1;
         end
         S_JR: begin
            cu.M_selector_A = A_REG;
            cu.PC_w         = 1'b1;
         end
         // ALU computes PC-4 so EPC holds the faulting address
         S_EXC_OVF, S_EXC_OPC: begin
            cu.M_selector_B = B_FOUR;
            cu.ULA_c        = ULA_SUB;
            cu.EPC_w        = 1'b1;
            cu.exc_cause    = (state_q == S_EXC_OPC);
         end
         S_EXC_JMP: begin
            cu.M_selector_PCsrc = PC_EXC;
            cu.PC_w             = 1'b1;
            cu.exc_cause        = exc_q;
         end
         default: ;
      endcase
   end

endmodule
